// File: rtl/sd_clk_pkg.sv
// Shared types and divider constants for the SD clock generator.
package sd_clk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sd_clk_state_t;

  localparam int SD_DIV_INIT_100M = 250;
  localparam int SD_DIV_FAST_100M = 4;
  localparam int SD_DIV_MIN       = 2;

endpackage

// File: rtl/sd_clk_divider.sv
// Programmable SD card clock generator with glitch-free divider changes and
// stop/start applied only at period boundaries.
module sd_clk_divider
  import sd_clk_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int INIT_DIV = SD_DIV_INIT_100M
) (
  input  logic             clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             sclk,
  output logic             rise_stb,
  output logic             fall_stb,
  output logic             div_ack,
  output logic [CNT_W-1:0] cur_div,
  output logic             idle
);

  sd_clk_state_t    r_state;
  sd_clk_state_t    w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_cur_div;
  logic [CNT_W-1:0] w_cur_div_nxt;
  logic [CNT_W-1:0] r_pend_div;
  logic [CNT_W-1:0] w_pend_div_nxt;
  logic             r_pend_vld;
  logic             w_pend_vld_nxt;
  logic             r_sclk;
  logic             w_sclk_nxt;
  logic             r_rise;
  logic             w_rise_nxt;
  logic             r_fall;
  logic             w_fall_nxt;
  logic             r_ack;
  logic             w_ack_nxt;
  logic             r_idle;

  logic [CNT_W-1:0] w_load_div;
  logic [CNT_W-1:0] w_eff_div;
  logic             w_eff_new;
  logic             w_wrap;
  logic             w_apply;
  logic [CNT_W-1:0] w_low_eff;
  logic [CNT_W-1:0] w_low_cur;
  logic [CNT_W-1:0] w_cnt_inc;

  // Low phase length ceil(D/2); computed one bit wider so D at full scale cannot overflow.
  function automatic logic [CNT_W-1:0] lowLen(input logic [CNT_W-1:0] d);
    logic [CNT_W:0] s;
    s = {1'b0, d} + {{CNT_W{1'b0}}, 1'b1};
    return s[CNT_W:1];
  endfunction

  assign w_load_div = (div_in < CNT_W'(SD_DIV_MIN)) ? CNT_W'(SD_DIV_MIN) : div_in;
  // A load arriving on the application edge bypasses the pending register.
  assign w_eff_div  = div_load ? w_load_div : (r_pend_vld ? r_pend_div : r_cur_div);
  assign w_eff_new  = div_load | r_pend_vld;
  assign w_wrap     = (r_cnt == (r_cur_div - CNT_W'(1)));
  assign w_apply    = (r_state == IDLE) | w_wrap;
  assign w_low_eff  = lowLen(w_eff_div);
  assign w_low_cur  = lowLen(r_cur_div);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cur_div  <= CNT_W'(INIT_DIV);
      r_pend_div <= '0;
      r_pend_vld <= 1'b0;
      r_sclk     <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_ack      <= 1'b0;
      r_idle     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_cur_div  <= w_cur_div_nxt;
      r_pend_div <= w_pend_div_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_sclk     <= w_sclk_nxt;
      r_rise     <= w_rise_nxt;
      r_fall     <= w_fall_nxt;
      r_ack      <= w_ack_nxt;
      r_idle     <= (w_state_nxt == IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en) w_state_nxt = RUN;
      RUN:     if (w_wrap && !en) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_cur_div_nxt  = r_cur_div;
    w_pend_div_nxt = r_pend_div;
    w_pend_vld_nxt = r_pend_vld;
    w_sclk_nxt     = 1'b0;
    w_rise_nxt     = 1'b0;
    w_fall_nxt     = 1'b0;
    w_ack_nxt      = 1'b0;

    if (w_apply) begin
      w_cur_div_nxt  = w_eff_div;
      w_pend_vld_nxt = 1'b0;
      w_ack_nxt      = w_eff_new;
    end else if (div_load) begin
      w_pend_div_nxt = w_load_div;
      w_pend_vld_nxt = 1'b1;
    end

    case (r_state)
      IDLE: begin
        if (en) begin
          w_cnt_nxt  = CNT_W'(1);
          w_sclk_nxt = (CNT_W'(1) >= w_low_eff);
          w_rise_nxt = (CNT_W'(1) == w_low_eff);
        end else begin
          w_cnt_nxt  = '0;
        end
      end
      RUN: begin
        // The wrap edge always lands on cnt=0, which is low for any divider.
        if (w_wrap) begin
          w_cnt_nxt  = '0;
          w_fall_nxt = 1'b1;
        end else begin
          w_cnt_nxt  = w_cnt_inc;
          w_sclk_nxt = (w_cnt_inc >= w_low_cur);
          w_rise_nxt = (w_cnt_inc == w_low_cur);
        end
      end
      default: w_cnt_nxt = '0;
    endcase
  end

  assign sclk     = r_sclk;
  assign rise_stb = r_rise;
  assign fall_stb = r_fall;
  assign div_ack  = r_ack;
  assign cur_div  = r_cur_div;
  assign idle     = r_idle;

endmodule

// File: tb/tb_sd_clk_divider.sv
// Directed, table-driven bench for sd_clk_divider with hand-computed expectations.
module tb_sd_clk_divider;
  import sd_clk_pkg::*;

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       en;
  logic [7:0] div_in;
  logic       div_load;
  logic       sclk;
  logic       rise_stb;
  logic       fall_stb;
  logic       div_ack;
  logic [7:0] cur_div;
  logic       idle;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       en;
    logic       load;
    logic [7:0] div;
    logic       sclk;
    logic       rise;
    logic       fall;
    logic       ack;
    logic       idle;
    logic [7:0] cur;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  sd_clk_divider #(.CNT_W(8), .INIT_DIV(SD_DIV_INIT_100M)) dut (
    .clk      (clk),
    .sys_rst_n(sys_rst_n),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .sclk     (sclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb),
    .div_ack  (div_ack),
    .cur_div  (cur_div),
    .idle     (idle)
  );

  function automatic logic [12:0] outs();
    return {sclk, rise_stb, fall_stb, div_ack, idle, cur_div};
  endfunction

  task automatic checkOutput(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual{sclk,rise,fall,ack,idle,cur}=%b_%h expected=%b_%h",
               name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic l, input logic [7:0] d);
    @(negedge clk);
    en       = e;
    div_load = l;
    div_in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    sys_rst_n = 1'b0;
    en        = 1'b0;
    div_load  = 1'b0;
    div_in    = 8'd0;
    @(posedge clk);
    #1;
    checkOutput("reset", outs(), {5'b00001, 8'd250});
    @(negedge clk);
    sys_rst_n = 1'b1;
  endtask

  function automatic void addVec(input logic e, input logic l, input logic [7:0] d,
                                 input logic s, input logic r, input logic f,
                                 input logic a, input logic i, input logic [7:0] c);
    vec_t v;
    v.en = e; v.load = l; v.div = d;
    v.sclk = s; v.rise = r; v.fall = f; v.ack = a; v.idle = i; v.cur = c;
    vecs.push_back(v);
  endfunction

  initial begin
    int n;
    sys_rst_n = 1'b1;
    en        = 1'b0;
    div_load  = 1'b0;
    div_in    = 8'd0;

    //     en ld div   sclk rise fall ack idle cur
    addVec(0, 1, 8'd4,  0, 0, 0, 1, 1, 8'd4);  // load in IDLE, 1-cycle latency
    addVec(1, 0, 8'd0,  0, 0, 0, 0, 0, 8'd4);  // start, cnt=1
    addVec(1, 0, 8'd0,  1, 1, 0, 0, 0, 8'd4);
    addVec(1, 0, 8'd0,  1, 0, 0, 0, 0, 8'd4);
    addVec(1, 0, 8'd0,  0, 0, 1, 0, 0, 8'd4);  // wrap
    addVec(1, 0, 8'd0,  0, 0, 0, 0, 0, 8'd4);
    addVec(1, 0, 8'd0,  1, 1, 0, 0, 0, 8'd4);
    addVec(1, 1, 8'd4,  1, 0, 0, 0, 0, 8'd4);  // load mid-high -> pending
    addVec(1, 0, 8'd0,  0, 0, 1, 1, 0, 8'd4);  // applied at wrap, ack
    addVec(1, 0, 8'd0,  0, 0, 0, 0, 0, 8'd4);
    addVec(1, 1, 8'd5,  1, 1, 0, 0, 0, 8'd4);  // pending 5
    addVec(1, 1, 8'd1,  1, 0, 0, 0, 0, 8'd4);  // overwritten by 1 -> clamps to 2
    addVec(1, 0, 8'd0,  0, 0, 1, 1, 0, 8'd2);
    addVec(1, 0, 8'd0,  1, 1, 0, 0, 0, 8'd2);  // D=2 alternates
    addVec(1, 0, 8'd0,  0, 0, 1, 0, 0, 8'd2);  // no second ack
    addVec(1, 0, 8'd0,  1, 1, 0, 0, 0, 8'd2);
    addVec(1, 0, 8'd0,  0, 0, 1, 0, 0, 8'd2);
    addVec(1, 0, 8'd0,  1, 1, 0, 0, 0, 8'd2);
    addVec(1, 1, 8'd4,  0, 0, 1, 1, 0, 8'd4);  // load on wrap edge applies directly
    addVec(1, 0, 8'd0,  0, 0, 0, 0, 0, 8'd4);
    addVec(1, 0, 8'd0,  1, 1, 0, 0, 0, 8'd4);
    addVec(0, 0, 8'd0,  1, 0, 0, 0, 0, 8'd4);  // stop requested mid-high
    addVec(0, 0, 8'd0,  0, 0, 1, 0, 1, 8'd4);  // high phase completes, then IDLE
    addVec(0, 0, 8'd0,  0, 0, 0, 0, 1, 8'd4);
    addVec(0, 0, 8'd0,  0, 0, 0, 0, 1, 8'd4);
    addVec(1, 1, 8'd5,  0, 0, 0, 1, 0, 8'd5);  // start and load together
    addVec(1, 0, 8'd0,  0, 0, 0, 0, 0, 8'd5);
    addVec(1, 0, 8'd0,  1, 1, 0, 0, 0, 8'd5);
    addVec(1, 0, 8'd0,  1, 0, 0, 0, 0, 8'd5);
    addVec(1, 0, 8'd0,  0, 0, 1, 0, 0, 8'd5);
    addVec(1, 0, 8'd0,  0, 0, 0, 0, 0, 8'd5);
    addVec(1, 0, 8'd0,  0, 0, 0, 0, 0, 8'd5);
    addVec(1, 0, 8'd0,  1, 1, 0, 0, 0, 8'd5);

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].en, vecs[i].load, vecs[i].div);
      checkOutput($sformatf("vec%0d", i), outs(),
                  {vecs[i].sclk, vecs[i].rise, vecs[i].fall, vecs[i].ack, vecs[i].idle, vecs[i].cur});
    end

    // Reset while sclk is high must clear everything on the next edge.
    doReset();

    // Default divider: low 125, high 125.
    applyStimulus(1, 0, 8'd0);
    checkOutput("init_start", outs(), {5'b00000, 8'd250});
    n = 0;
    do begin
      applyStimulus(1, 0, 8'd0);
      n++;
    end while (!rise_stb && n < 300);
    checkCount("init_edges_to_rise", n, 124);
    checkCount("init_sclk_at_rise", int'(sclk), 1);
    n = 0;
    do begin
      applyStimulus(1, 0, 8'd0);
      n++;
    end while (!fall_stb && n < 300);
    checkCount("init_high_len", n, 125);
    n = 0;
    do begin
      applyStimulus(1, 0, 8'd0);
      n++;
    end while (!rise_stb && n < 300);
    checkCount("init_low_len", n, 125);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_clk_divider.md
# sd_clk_divider

Programmable SD-card clock generator for the SD controller path: produces a level SD clock (`sclk`) plus single-cycle rise/fall strobes derived from the system clock. It supports runtime divider reprogramming, needed for the 400 kHz init to 25 MHz data switch, with glitch-free changes applied only at period boundaries. It also supports clock stop/start so the controller can stall the card clock between transfers.

## Interface
- `CNT_W`, default 8: divider/counter width.
- `INIT_DIV`, default 250: divider after reset (100 MHz / 250 = 400 kHz).
- `clk`  in  1: system clock (100 MHz).
- `sys_rst_n`  in  1: reset, synchronous, active-low.
- `en`  in  1: run request; 1 = generate clock, 0 = stop at next period boundary.
- `div_in`  in  CNT_W: requested divider D.
- `div_load`  in  1: one-cycle pulse capturing `div_in` as pending divider.
- `sclk`  out  1: SD clock level, registered.
- `rise_stb`  out  1: high for exactly the cycle in which `sclk` first reads 1.
- `fall_stb`  out  1: high for exactly the cycle in which `sclk` first reads 0 after a high phase.
- `div_ack`  out  1: one-cycle pulse, cycle after pending divider becomes active.
- `cur_div`  out  CNT_W: active divider.
- `idle`  out  1: 1 when clock stopped (state IDLE).

## Operation
- States: IDLE, RUN.
- Counter `cnt` runs 0..D-1. Low length L = ceil(D/2) = (D+1)>>1; high length D-L.
- In RUN at each edge: `cnt_n` = (cnt==D-1) ? 0 : cnt+1; `sclk` <= (cnt_n >= L); `rise_stb` <= (cnt_n==L); `fall_stb` <= (cnt_n==0).
- D=4: sclk 0,0,1,1 repeating. D=5: 0,0,0,1,1. D=2: 0,1.
- IDLE: cnt held 0, sclk 0, strobes 0. When `en`=1 is sampled, go to RUN with cnt <= 1; first rise L cycles after the sampling edge.
- RUN with `en`=0: keep running until the wrap edge (cnt==D-1). At that edge go to IDLE, cnt <= 0, sclk <= 0, fall_stb <= 1. A high phase is never truncated; no runt pulses.
- Divider load:
  - `div_load` captures `div_in` into the pending register and sets the pending flag.
  - Values < 2 clamp to 2.
  - A later `div_load` before application overwrites the pending value; only one `div_ack` is issued.
  - Pending is applied at the wrap edge in RUN, or at the next edge in IDLE.
  - Sequence: `cur_div` updates at that edge; `div_ack` is high the following cycle.
  - The new D governs the period starting at cnt=0.
- Simultaneous events:
  - `div_load` in the same cycle as the wrap edge: `div_in` is applied directly at that edge.
  - `en` rise and `div_load` in the same IDLE cycle: the new D is applied, and RUN starts with it.
  - `en`=0 and a pending divider at the wrap edge: the divider is applied and the block enters IDLE.
- Reset (any time, including mid-period): state IDLE, cnt 0, `sclk` 0, `rise_stb` 0, `fall_stb` 0, `div_ack` 0, pending cleared, `cur_div` = INIT_DIV, `idle` 1.

## Timing
- All outputs are registered; no combinational input-to-output path.
- `en` to first `rise_stb`: L cycles after the sampling edge.
- Stop latency: at most D cycles (the remaining current period).
- Divider change latency: at most D_old cycles in RUN; 1 cycle in IDLE; `div_ack` 1 cycle after application.
- `idle` reflects state registered: 1 in the cycle after the stopping edge; 0 in the cycle after the RUN-entry edge.

## Structure
- Package `sd_clk_pkg` holds:
  - state enum `sd_clk_state_t` {IDLE, RUN};
  - constants `SD_DIV_INIT_100M` = 250, `SD_DIV_FAST_100M` = 4, `SD_DIV_MIN` = 2.
- Single module; counter, pending register and FSM are inline. No sub-module is warranted.

## Test plan
- Reset, `en`=1, D=250 → after 125 cycles `rise_stb`; period 250; high 125 cycles; `idle` drops.
- D=4, `div_load` mid-high-phase → current 4-cycle period completes; next period uses D=4 (sclk 0,0,1,1); `div_ack` one cycle after the wrap edge.
- `div_in`=5 then `div_in`=1 loaded before wrap → single `div_ack`, `cur_div`=2, sclk 0,1 alternating.
- `en` dropped during high phase with D=4 → high phase completes, `fall_stb` at wrap, `idle`=1, `sclk` held 0, no further strobes.
- From IDLE, `en`=1 and `div_load` (`div_in`=5) in the same cycle → `cur_div`=5, first rise 3 cycles later, low 3 / high 2.
- `sys_rst_n`=0 mid-high-phase → next cycle `sclk`=0, strobes 0, `cur_div`=250, `idle`=1.
